// File: rtl/pf_lanectrl_dly_seq.sv
// Delay-line step sequencer: walks the RX/TX DQS delay line to an absolute tap inside an HS_IO_CLK_PAUSE window.
// Define PF_LANECTRL_DLY_SEQ_MOVE_CNT_EN to add the saturating MOVE_CNT output.
module pf_lanectrl_dly_seq #(
    parameter int unsigned TAP_W       = 8,
    parameter int unsigned DEFAULT_TAP = 1,
    parameter int unsigned MOVE_GAP    = 4,
    parameter int unsigned PAUSE_PRE   = 2,
    parameter int unsigned PAUSE_POST  = 2
) (
    input  logic             FAB_CLK,
    input  logic             RESET,
    input  logic             REQ_VALID,
    output logic             REQ_READY,
    input  logic             REQ_LOAD,
    input  logic             REQ_SEL,
    input  logic [TAP_W-1:0] REQ_TAP,
    output logic             DONE,
    output logic             ERR,
    output logic [TAP_W-1:0] RX_TAP,
    output logic [TAP_W-1:0] TX_TAP,
    output logic             DELAY_LINE_SEL,
    output logic             DELAY_LINE_LOAD,
    output logic             DELAY_LINE_DIRECTION,
    output logic             DELAY_LINE_MOVE,
    output logic             HS_IO_CLK_PAUSE,
    input  logic             RX_DELAY_LINE_OUT_OF_RANGE,
`ifdef PF_LANECTRL_DLY_SEQ_MOVE_CNT_EN
    output logic [15:0]      MOVE_CNT,
`endif
    input  logic             TX_DELAY_LINE_OUT_OF_RANGE
);

    localparam int unsigned MAX_A   = (MOVE_GAP > PAUSE_PRE) ? MOVE_GAP : PAUSE_PRE;
    localparam int unsigned CNT_MAX = (MAX_A > PAUSE_POST) ? MAX_A : PAUSE_POST;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_MOVE, S_GAP, S_POST, S_LOAD, S_FIN
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [TAP_W-1:0]   tgt_q, rx_q, tx_q;
    logic               sel_q, dir_q, err_q;
    logic               ready_q, pause_q, move_q, load_q, done_q;
    logic               ready_d, pause_d, move_d, load_d, done_d, sel_d, dir_d;
    logic               accept, oor_sel, abort;
    logic [TAP_W-1:0]   cur_req, cur_run;

    assign accept  = REQ_VALID && ready_q;
    assign cur_req = REQ_SEL ? tx_q : rx_q;
    assign cur_run = sel_q ? tx_q : rx_q;
    // Only the selected line's range flag can abort a run
    assign oor_sel = sel_q ? TX_DELAY_LINE_OUT_OF_RANGE : RX_DELAY_LINE_OUT_OF_RANGE;
    assign abort   = ((state_q == S_MOVE) || (state_q == S_GAP)) && oor_sel;

    // State register and per-state cycle counter
    always_ff @(posedge FAB_CLK) begin
        if (RESET) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (REQ_LOAD)                state_d = S_LOAD;
                    else if (REQ_TAP == cur_req) state_d = S_FIN;
                    else                         state_d = S_PRE;
                end
            end
            S_PRE:  if (cnt_q == CNT_W'(PAUSE_PRE - 1)) state_d = S_MOVE;
            S_MOVE: state_d = oor_sel ? S_POST : S_GAP;
            S_GAP: begin
                if (oor_sel)
                    state_d = S_POST;
                else if (cnt_q == CNT_W'(MOVE_GAP - 1))
                    state_d = (cur_run != tgt_q) ? S_MOVE : S_POST;
            end
            S_POST: if (cnt_q == CNT_W'(PAUSE_POST - 1)) state_d = S_FIN;
            S_LOAD: state_d = S_FIN;
            S_FIN:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from the next state, registered below
    always_comb begin
        ready_d = (state_d == S_IDLE);
        pause_d = (state_d == S_PRE) || (state_d == S_MOVE) ||
                  (state_d == S_GAP) || (state_d == S_POST);
        move_d  = (state_d == S_MOVE);
        load_d  = (state_d == S_LOAD);
        done_d  = (state_d == S_FIN);
        sel_d   = sel_q;
        dir_d   = dir_q;
        if (accept) begin
            sel_d = REQ_SEL;
            if (!REQ_LOAD) dir_d = (REQ_TAP > cur_req);
        end
    end

    // Registered outputs, trackers and sticky error
    always_ff @(posedge FAB_CLK) begin
        if (RESET) begin
            ready_q <= 1'b1;
            pause_q <= 1'b0;
            move_q  <= 1'b0;
            load_q  <= 1'b0;
            done_q  <= 1'b0;
            sel_q   <= 1'b0;
            dir_q   <= 1'b0;
            err_q   <= 1'b0;
            tgt_q   <= '0;
            rx_q    <= TAP_W'(DEFAULT_TAP);
            tx_q    <= TAP_W'(DEFAULT_TAP);
        end else begin
            ready_q <= ready_d;
            pause_q <= pause_d;
            move_q  <= move_d;
            load_q  <= load_d;
            done_q  <= done_d;
            sel_q   <= sel_d;
            dir_q   <= dir_d;
            if (accept) tgt_q <= REQ_TAP;
            // Tracker steps on the same edge that raises DELAY_LINE_MOVE
            if (state_d == S_MOVE) begin
                if (sel_q) tx_q <= dir_q ? tx_q + TAP_W'(1) : tx_q - TAP_W'(1);
                else       rx_q <= dir_q ? rx_q + TAP_W'(1) : rx_q - TAP_W'(1);
            end
            if (state_q == S_LOAD) begin
                if (sel_q) tx_q <= TAP_W'(DEFAULT_TAP);
                else       rx_q <= TAP_W'(DEFAULT_TAP);
                err_q <= 1'b0;
            end else if (abort) begin
                err_q <= 1'b1;
            end
        end
    end

`ifdef PF_LANECTRL_DLY_SEQ_MOVE_CNT_EN
    logic [15:0] move_cnt_q;

    // Saturating count of MOVE pulses since reset
    always_ff @(posedge FAB_CLK) begin
        if (RESET)
            move_cnt_q <= '0;
        else if ((state_d == S_MOVE) && (move_cnt_q != 16'hFFFF))
            move_cnt_q <= move_cnt_q + 16'd1;
    end

    assign MOVE_CNT = move_cnt_q;
`endif

    assign REQ_READY            = ready_q;
    assign DONE                 = done_q;
    assign ERR                  = err_q;
    assign RX_TAP               = rx_q;
    assign TX_TAP               = tx_q;
    assign DELAY_LINE_SEL       = sel_q;
    assign DELAY_LINE_LOAD      = load_q;
    assign DELAY_LINE_DIRECTION = dir_q;
    assign DELAY_LINE_MOVE      = move_q;
    assign HS_IO_CLK_PAUSE      = pause_q;

endmodule

// File: tb/tb_pf_lanectrl_dly_seq.sv
// Testbench for pf_lanectrl_dly_seq: directed table, reset-mid-run sequence and randomized requests vs a tap model.
module tb_pf_lanectrl_dly_seq;

    localparam int unsigned TAP_W = 8;
    localparam int DEF = 1;
    localparam int G   = 4;
    localparam int PP  = 2;
    localparam int PO  = 2;

    logic             FAB_CLK = 1'b0;
    logic             RESET = 1'b1;
    logic             REQ_VALID = 1'b0;
    logic             REQ_READY;
    logic             REQ_LOAD = 1'b0;
    logic             REQ_SEL = 1'b0;
    logic [TAP_W-1:0] REQ_TAP = '0;
    logic             DONE, ERR;
    logic [TAP_W-1:0] RX_TAP, TX_TAP;
    logic             DELAY_LINE_SEL, DELAY_LINE_LOAD, DELAY_LINE_DIRECTION;
    logic             DELAY_LINE_MOVE, HS_IO_CLK_PAUSE;
    logic             RX_OOR = 1'b0;
    logic             TX_OOR = 1'b0;
`ifdef PF_LANECTRL_DLY_SEQ_MOVE_CNT_EN
    logic [15:0]      MOVE_CNT;
`endif

    pf_lanectrl_dly_seq dut (
        .FAB_CLK                    (FAB_CLK),
        .RESET                      (RESET),
        .REQ_VALID                  (REQ_VALID),
        .REQ_READY                  (REQ_READY),
        .REQ_LOAD                   (REQ_LOAD),
        .REQ_SEL                    (REQ_SEL),
        .REQ_TAP                    (REQ_TAP),
        .DONE                       (DONE),
        .ERR                        (ERR),
        .RX_TAP                     (RX_TAP),
        .TX_TAP                     (TX_TAP),
        .DELAY_LINE_SEL             (DELAY_LINE_SEL),
        .DELAY_LINE_LOAD            (DELAY_LINE_LOAD),
        .DELAY_LINE_DIRECTION       (DELAY_LINE_DIRECTION),
        .DELAY_LINE_MOVE            (DELAY_LINE_MOVE),
        .HS_IO_CLK_PAUSE            (HS_IO_CLK_PAUSE),
        .RX_DELAY_LINE_OUT_OF_RANGE (RX_OOR),
`ifdef PF_LANECTRL_DLY_SEQ_MOVE_CNT_EN
        .MOVE_CNT                   (MOVE_CNT),
`endif
        .TX_DELAY_LINE_OUT_OF_RANGE (TX_OOR)
    );

    always #5 FAB_CLK = ~FAB_CLK;

    typedef struct {
        int load; int sel; int tap; int abort_at; int oor_other;
        int e_moves; int e_dir; int e_lat; int e_rx; int e_tx; int e_err;
    } vec_t;

    int total = 0;
    int bad   = 0;
    int rx_m, tx_m, err_m, mv_total;
    vec_t tbl [12];

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Expected outcome of a request from the tracked tap state and the stepping rules
    function automatic vec_t model(input int load, input int sel, input int tap,
                                   input int abort_at, input int other);
        vec_t v;
        int cur, n, m;
        v.load = load; v.sel = sel; v.tap = tap; v.abort_at = abort_at; v.oor_other = other;
        v.e_moves = 0; v.e_dir = 0; v.e_err = err_m; v.e_rx = rx_m; v.e_tx = tx_m;
        cur = (sel != 0) ? tx_m : rx_m;
        if (load != 0) begin
            v.e_lat = 2; v.e_err = 0;
            if (sel != 0) v.e_tx = DEF; else v.e_rx = DEF;
        end else if (tap == cur) begin
            v.e_lat = 1;
        end else begin
            n = (tap > cur) ? tap - cur : cur - tap;
            v.e_dir = (tap > cur) ? 1 : 0;
            if (abort_at >= 1 && abort_at <= n) begin
                m = abort_at;
                v.e_err = 1;
                v.e_lat = PP + (m - 1) * (1 + G) + 1 + PO + 1;
            end else begin
                m = n;
                v.e_lat = PP + n * (1 + G) + PO + 1;
            end
            v.e_moves = m;
            if (sel != 0) v.e_tx = (v.e_dir != 0) ? cur + m : cur - m;
            else          v.e_rx = (v.e_dir != 0) ? cur + m : cur - m;
        end
        return v;
    endfunction

    task automatic run_req(input vec_t v);
        int moves = 0, pcnt = 0, lcnt = 0, lat = 0, last = 0;
        int dir_bad = 0, gap_bad = 0, sel_bad = 0, rdy_bad = 0;
        @(negedge FAB_CLK);
        REQ_VALID = 1'b1;
        REQ_LOAD  = (v.load != 0);
        REQ_SEL   = (v.sel != 0);
        REQ_TAP   = TAP_W'(v.tap);
        if (v.oor_other != 0) begin
            if (v.sel != 0) RX_OOR = 1'b1; else TX_OOR = 1'b1;
        end
        for (int k = 1; k <= 2000 && lat == 0; k++) begin
            @(negedge FAB_CLK);
            REQ_VALID = 1'b0;
            if (DELAY_LINE_MOVE) begin
                moves++;
                if (DELAY_LINE_DIRECTION != (v.e_dir != 0)) dir_bad++;
                if (moves > 1 && k - last != 1 + G) gap_bad++;
                last = k;
                if (moves == v.abort_at) begin
                    if (v.sel != 0) TX_OOR = 1'b1; else RX_OOR = 1'b1;
                end
            end
            if ((DELAY_LINE_MOVE || DELAY_LINE_LOAD) && DELAY_LINE_SEL != (v.sel != 0)) sel_bad++;
            if (HS_IO_CLK_PAUSE) pcnt++;
            if (DELAY_LINE_LOAD) lcnt++;
            if (REQ_READY) rdy_bad++;
            if (DONE) lat = k;
        end
        chk("done_latency", lat, v.e_lat);
        @(negedge FAB_CLK);
        RX_OOR = 1'b0;
        TX_OOR = 1'b0;
        chk("ready_after_done", REQ_READY, 1);
        chk("done_single_pulse", DONE, 0);
        chk("move_pulses", moves, v.e_moves);
        chk("pause_cycles", pcnt, (v.e_moves > 0) ? v.e_lat - 1 : 0);
        chk("load_pulses", lcnt, v.load);
        chk("rx_tap", RX_TAP, v.e_rx);
        chk("tx_tap", TX_TAP, v.e_tx);
        chk("err", ERR, v.e_err);
        chk("dir_errors", dir_bad, 0);
        chk("move_spacing_errors", gap_bad, 0);
        chk("sel_errors", sel_bad, 0);
        chk("ready_during_run", rdy_bad, 0);
        rx_m  = v.e_rx;
        tx_m  = v.e_tx;
        err_m = v.e_err;
        mv_total = (mv_total + v.e_moves > 65535) ? 65535 : mv_total + v.e_moves;
`ifdef PF_LANECTRL_DLY_SEQ_MOVE_CNT_EN
        chk("move_cnt", MOVE_CNT, mv_total);
`endif
    endtask

    initial begin
        int dcnt, moves, cur, tap, ab;
        vec_t v;

        //           load sel tap ab oth  mv dir lat  rx  tx  err
        tbl[0]  = '{0, 1,   1, 0, 0,   0, 0,    1, 1,   1, 0};
        tbl[1]  = '{0, 1,   5, 0, 0,   4, 1,   25, 1,   5, 0};
        tbl[2]  = '{0, 0,   0, 0, 0,   1, 0,   10, 0,   5, 0};
        tbl[3]  = '{1, 1,   0, 0, 0,   0, 0,    2, 0,   1, 0};
        tbl[4]  = '{0, 1, 200, 3, 0,   3, 1,   16, 0,   4, 1};
        tbl[5]  = '{1, 1,   0, 0, 0,   0, 0,    2, 0,   1, 0};
        tbl[6]  = '{0, 0,   3, 0, 1,   3, 1,   20, 3,   1, 0};
        tbl[7]  = '{0, 1, 255, 0, 0, 254, 1, 1275, 3, 255, 0};
        tbl[8]  = '{0, 1, 254, 1, 0,   1, 0,    6, 3, 254, 1};
        tbl[9]  = '{0, 0,   2, 0, 0,   1, 0,   10, 2, 254, 1};
        tbl[10] = '{1, 0,  77, 0, 0,   0, 0,    2, 1, 254, 0};
        tbl[11] = '{1, 1,   9, 0, 0,   0, 0,    2, 1,   1, 0};

        repeat (3) @(posedge FAB_CLK);
        @(negedge FAB_CLK);
        RESET = 1'b0;
        @(negedge FAB_CLK);
        chk("reset_ready", REQ_READY, 1);
        chk("reset_done", DONE, 0);
        chk("reset_err", ERR, 0);
        chk("reset_rx_tap", RX_TAP, DEF);
        chk("reset_tx_tap", TX_TAP, DEF);
        chk("reset_pause", HS_IO_CLK_PAUSE, 0);
        chk("reset_move", DELAY_LINE_MOVE, 0);
        chk("reset_load", DELAY_LINE_LOAD, 0);
        chk("reset_dir", DELAY_LINE_DIRECTION, 0);
        chk("reset_sel", DELAY_LINE_SEL, 0);
        rx_m = DEF; tx_m = DEF; err_m = 0; mv_total = 0;

        for (int i = 0; i < 12; i++) run_req(tbl[i]);

        // Reset during the gap of a 10-tap TX run
        @(negedge FAB_CLK);
        REQ_VALID = 1'b1; REQ_LOAD = 1'b0; REQ_SEL = 1'b1; REQ_TAP = TAP_W'(tx_m + 10);
        moves = 0;
        for (int k = 0; k < 100 && moves < 2; k++) begin
            @(negedge FAB_CLK);
            REQ_VALID = 1'b0;
            if (DELAY_LINE_MOVE) moves++;
        end
        chk("reset_run_moves_seen", moves, 2);
        @(negedge FAB_CLK);
        RESET = 1'b1;
        @(negedge FAB_CLK);
        RESET = 1'b0;
        chk("midrun_reset_pause", HS_IO_CLK_PAUSE, 0);
        chk("midrun_reset_ready", REQ_READY, 1);
        chk("midrun_reset_tx_tap", TX_TAP, DEF);
        chk("midrun_reset_rx_tap", RX_TAP, DEF);
        chk("midrun_reset_done", DONE, 0);
        dcnt = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge FAB_CLK);
            if (DONE || DELAY_LINE_MOVE) dcnt++;
        end
        chk("midrun_reset_no_done", dcnt, 0);
        rx_m = DEF; tx_m = DEF; err_m = 0; mv_total = 0;

        // Randomized requests against the model
        for (int i = 0; i < 30; i++) begin
            int load, sel, oth;
            load = ($urandom_range(0, 7) == 0) ? 1 : 0;
            sel  = int'($urandom_range(0, 1));
            oth  = int'($urandom_range(0, 1));
            cur  = (sel != 0) ? tx_m : rx_m;
            tap  = cur + int'($urandom_range(0, 16)) - 8;
            if (tap < 0) tap = 0;
            if (tap > 255) tap = 255;
            ab   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            v = model(load, sel, tap, ab, oth);
            run_req(v);
        end

`ifdef PF_LANECTRL_DLY_SEQ_MOVE_CNT_EN
        // Saturation of the move counter
        @(negedge FAB_CLK);
        force dut.move_cnt_q = 16'hFFFE;
        @(negedge FAB_CLK);
        release dut.move_cnt_q;
        mv_total = 65534;
        v = model(0, 0, (rx_m > 100) ? rx_m - 3 : rx_m + 3, 0, 0);
        run_req(v);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
